// File: rtl/instruction_sequencer_if.sv
// Fetch and data-memory handshake bundle between the sequencer (master) and
// the memory subsystem (slave).
interface instruction_sequencer_if #(
   parameter int INST_W   = 16,
   parameter int I_ADDR_W = 12
);
   logic                imem_req;
   logic [I_ADDR_W-1:0] imem_addr;
   logic                imem_ready;
   logic                imem_rsp_valid;
   logic [INST_W-1:0]   imem_rsp_data;
   logic                dmem_req;
   logic                dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req,
      input  imem_ready, imem_rsp_valid, imem_rsp_data, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req,
      output imem_ready, imem_rsp_valid, imem_rsp_data, dmem_ack
   );
endinterface

// File: rtl/instruction_sequencer.sv
// Fetch / execute / memory-wait control for a simple processor: owns the
// instruction register, gates decoder write enables and counts retirements.
module instruction_sequencer #(
   parameter int INST_W   = 16,
   parameter int I_ADDR_W = 12,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic                halt_req,
   input  logic [I_ADDR_W-1:0] pc_value,
   instruction_sequencer_if.master bus,
   output logic [INST_W-1:0]   instruction,
   input  logic                dec_dmem_we,
   input  logic                dec_dmem_oe,
   output logic                exec_commit,
   output logic                pc_advance,
   output logic                halted,
   output logic [CNT_W-1:0]    retired_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_REQ,
      S_FETCH_WAIT,
      S_EXECUTE,
      S_MEM_WAIT,
      S_HALT
   } state_t;

   state_t            state_reg, state_next;
   logic [INST_W-1:0] instruction_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              imem_req_reg;
   logic              dmem_req_reg;
   logic              halted_reg;
   logic              retire;
   logic              mem_op;
   logic              capture;

   assign mem_op  = dec_dmem_we | dec_dmem_oe;
   assign capture = (state_reg == S_FETCH_WAIT) && bus.imem_rsp_valid;

   // Retire must be combinational: the commit strobe has to land in the same
   // cycle as the dmem_ack or the non-memory EXECUTE cycle.
   always_comb begin
      state_next = state_reg;
      retire     = 1'b0;
      case (state_reg)
         S_IDLE:       if (run) state_next = S_FETCH_REQ;
         S_FETCH_REQ:  if (bus.imem_ready) state_next = S_FETCH_WAIT;
         S_FETCH_WAIT: if (bus.imem_rsp_valid) state_next = S_EXECUTE;
         S_EXECUTE: begin
            if (mem_op) state_next = S_MEM_WAIT;
            else        retire     = 1'b1;
         end
         S_MEM_WAIT:   if (bus.dmem_ack) retire = 1'b1;
         S_HALT:       state_next = S_HALT;
         default:      state_next = S_IDLE;
      endcase
      if (retire) begin
         if (halt_req)  state_next = S_HALT;
         else if (!run) state_next = S_IDLE;
         else           state_next = S_FETCH_REQ;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         instruction_reg <= '0;
         count_reg       <= '0;
         imem_req_reg    <= 1'b0;
         dmem_req_reg    <= 1'b0;
         halted_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         imem_req_reg <= (state_next == S_FETCH_REQ);
         dmem_req_reg <= (state_next == S_MEM_WAIT);
         halted_reg   <= (state_next == S_HALT);
         if (capture) instruction_reg <= bus.imem_rsp_data;
         if (retire)  count_reg       <= count_reg + 1'b1;
      end
   end

   assign bus.imem_req  = imem_req_reg;
   assign bus.imem_addr = pc_value;
   assign bus.dmem_req  = dmem_req_reg;
   assign instruction   = instruction_reg;
   assign exec_commit   = retire;
   assign pc_advance    = retire;
   assign halted        = halted_reg;
   assign retired_count = count_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: instructions queued with hand-computed timing; a monitor
// checks every commit against the queue.
module tb_instruction_sequencer;
   localparam int INST_W   = 16;
   localparam int I_ADDR_W = 12;
   localparam int CNT_W    = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                run = 1'b0;
   logic                halt_req = 1'b0;
   logic [I_ADDR_W-1:0] pc_value = 12'h5A5;
   logic [INST_W-1:0]   instruction;
   logic                dec_dmem_we, dec_dmem_oe;
   logic                exec_commit, pc_advance, halted;
   logic [CNT_W-1:0]    retired_count;

   instruction_sequencer_if #(.INST_W(INST_W), .I_ADDR_W(I_ADDR_W)) bus_if ();

   instruction_sequencer #(.INST_W(INST_W), .I_ADDR_W(I_ADDR_W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .run           (run),
      .halt_req      (halt_req),
      .pc_value      (pc_value),
      .bus           (bus_if),
      .instruction   (instruction),
      .dec_dmem_we   (dec_dmem_we),
      .dec_dmem_oe   (dec_dmem_oe),
      .exec_commit   (exec_commit),
      .pc_advance    (pc_advance),
      .halted        (halted),
      .retired_count (retired_count)
   );

   always #5 clk = ~clk;

   // Toy decoder: opcode A = store, B = load.
   assign dec_dmem_we = (instruction[15:12] == 4'hA);
   assign dec_dmem_oe = (instruction[15:12] == 4'hB);

   typedef struct { logic [15:0] inst; int iwait; int dlat; } fetch_t;
   typedef struct { logic [15:0] inst; logic [CNT_W-1:0] cnt; int lat; int dcyc; int rlen; } exp_t;

   fetch_t mem_q[$];
   exp_t   sb_q[$];
   int     checks = 0;
   int     errors = 0;
   int     exp_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Latency = FETCH_REQ (1+iwait) + FETCH_WAIT + EXECUTE + MEM_WAIT (dlat).
   task automatic issue(input logic [15:0] inst, input int iwait, input int dlat);
      exp_t e;
      mem_q.push_back('{inst: inst, iwait: iwait, dlat: dlat});
      e.inst = inst;
      e.cnt  = exp_count[CNT_W-1:0];
      e.lat  = 3 + iwait + dlat;
      e.dcyc = dlat;
      e.rlen = iwait + 1;
      sb_q.push_back(e);
      exp_count = (exp_count + 1) % (1 << CNT_W);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         tick(1);
         n++;
      end
      check(name, sb_q.size(), 0);
      sb_q.delete();
      mem_q.delete();
   endtask

   task automatic run_batch(input string name);
      int n = 0;
      tick(1);
      run = 1'b1;
      while (mem_q.size() != 0 && n < 300) begin
         tick(1);
         n++;
      end
      run = 1'b0;
      drain(name);
      tick(2);
   endtask

   task automatic check_quiet(input string name, input int n);
      int seen = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus_if.imem_req) seen++;
      end
      check(name, seen, 0);
   endtask

   task automatic wait_dmem(input string name);
      int n = 0;
      while (!bus_if.dmem_req && n < 100) begin
         tick(1);
         n++;
      end
      check(name, bus_if.dmem_req, 1'b1);
   endtask

   // Memory responder: imem waits per entry, response one cycle after accept,
   // dmem_ack on the dlat-th cycle of dmem_req.
   initial begin : responder
      bit          fired = 0;
      bit          fetching = 0;
      int          wl = 0;
      int          dc = 0;
      int          cur_dlat = 0;
      logic [15:0] fired_inst = '0;
      fetch_t      f;
      bus_if.imem_ready     = 1'b0;
      bus_if.imem_rsp_valid = 1'b0;
      bus_if.imem_rsp_data  = '0;
      bus_if.dmem_ack       = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus_if.imem_rsp_valid = 1'b0;
         if (!rst_n) begin
            fired = 0;
            fetching = 0;
            dc = 0;
            bus_if.imem_ready = 1'b0;
            bus_if.dmem_ack = 1'b0;
         end else begin
            if (fired) begin
               bus_if.imem_rsp_valid = 1'b1;
               bus_if.imem_rsp_data  = fired_inst;
               fired = 0;
            end
            if (bus_if.imem_req && !fetching) begin
               fetching = 1;
               wl = (mem_q.size() > 0) ? mem_q[0].iwait : 0;
            end
            if (bus_if.imem_req && mem_q.size() > 0) begin
               if (wl > 0) begin
                  bus_if.imem_ready = 1'b0;
                  wl--;
               end else begin
                  bus_if.imem_ready = 1'b1;
                  f = mem_q.pop_front();
                  fired = 1;
                  fired_inst = f.inst;
                  cur_dlat = f.dlat;
                  fetching = 0;
               end
            end else begin
               bus_if.imem_ready = 1'b0;
            end
            if (bus_if.dmem_req) begin
               dc++;
               bus_if.dmem_ack = (dc == cur_dlat);
            end else begin
               dc = 0;
               bus_if.dmem_ack = 1'b0;
            end
         end
      end
   end

   initial begin : monitor
      int   cyc = 0;
      int   req_start = 0;
      int   req_len = 0;
      int   dmem_cyc = 0;
      bit   prev_req = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            dmem_cyc = 0;
            prev_req = 0;
            continue;
         end
         if (bus_if.imem_req) begin
            if (!prev_req) begin
               req_start = cyc;
               req_len = 0;
            end
            req_len++;
            if (bus_if.imem_ready) check("imem_addr", bus_if.imem_addr, pc_value);
         end
         prev_req = bus_if.imem_req;
         if (bus_if.dmem_req) dmem_cyc++;
         if (exec_commit || pc_advance) begin
            if (sb_q.size() == 0) begin
               check("unexpected_commit", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("commit_pair", {exec_commit, pc_advance}, 2'b11);
               check("instruction", instruction, e.inst);
               check("retired_count", retired_count, e.cnt);
               check("latency", cyc - req_start + 1, e.lat);
               check("dmem_cycles", dmem_cyc, e.dcyc);
               check("imem_req_cycles", req_len, e.rlen);
               $display("retire inst=%h count=%0d lat=%0d dmem=%0d", instruction,
                        retired_count, cyc - req_start + 1, dmem_cyc);
            end
            dmem_cyc = 0;
         end
         if (halted)
            check("halt_strobes", {bus_if.imem_req, bus_if.dmem_req, exec_commit, pc_advance}, 4'b0);
      end
   end

   initial begin : main
      tick(2);
      @(negedge clk);
      check("rst_imem_req", bus_if.imem_req, 1'b0);
      check("rst_dmem_req", bus_if.dmem_req, 1'b0);
      check("rst_commit", {exec_commit, pc_advance}, 2'b00);
      check("rst_halted", halted, 1'b0);
      check("rst_instruction", instruction, 16'h0);
      check("rst_count", retired_count, 4'h0);
      check("rst_imem_addr", bus_if.imem_addr, 12'h5A5);
      tick(1);
      rst_n = 1'b1;
      check_quiet("no_fetch_without_run", 4);

      pc_value = 12'h100;
      issue(16'h1234, 0, 0);
      run_batch("basic");
      check("count_after_basic", retired_count, 4'd1);
      check("instruction_held", instruction, 16'h1234);

      pc_value = 12'h101;
      issue(16'h2345, 4, 0);
      run_batch("imem_stall");

      pc_value = 12'h102;
      issue(16'hA001, 0, 3);
      run_batch("store");

      pc_value = 12'h103;
      issue(16'hB0F0, 0, 1);
      issue(16'h3003, 2, 0);
      issue(16'hA5A5, 1, 2);
      run_batch("mix");

      // run dropped while the load is in MEM_WAIT
      issue(16'hB777, 0, 5);
      tick(1);
      run = 1'b1;
      wait_dmem("reach_mem_wait");
      run = 1'b0;
      drain("run_drop");
      check_quiet("idle_after_run_drop", 10);

      // reset in the middle of a store: abandoned, never committed
      mem_q.push_back('{inst: 16'hA0A0, iwait: 0, dlat: 10});
      tick(1);
      run = 1'b1;
      wait_dmem("reach_mem_wait_rst");
      tick(2);
      run = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_dmem_req", bus_if.dmem_req, 1'b0);
      check("abort_commit", {exec_commit, pc_advance}, 2'b00);
      check("abort_count", retired_count, 4'h0);
      check("abort_instruction", instruction, 16'h0);
      tick(1);
      rst_n = 1'b1;
      mem_q.delete();
      exp_count = 0;
      tick(2);

      // halt at retire, then only reset leaves HALT
      halt_req = 1'b1;
      issue(16'h4444, 0, 0);
      tick(1);
      run = 1'b1;
      drain("halt_retire");
      tick(1);
      check("halted", halted, 1'b1);
      check_quiet("no_fetch_in_halt", 20);
      check("count_at_halt", retired_count, 4'd1);
      tick(1);
      run = 1'b0;
      halt_req = 1'b0;
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      exp_count = 0;
      @(negedge clk);
      check("halt_cleared", halted, 1'b0);
      check("count_cleared", retired_count, 4'd0);

      // 17 retires on a 4-bit counter wraps to 1
      for (int i = 0; i < 17; i++) issue(16'h0100 + 16'(i), i % 2, 0);
      run_batch("wrap");
      check("count_wrap", retired_count, 4'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter INST_W, default 16, instruction width.
REQ-002 Parameter I_ADDR_W, default 12, instruction address width.
REQ-003 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 run  in  1  level; 1 = fetch and execute, 0 = stop at the next instruction boundary.
REQ-008 halt_req  in  1  level; sampled at retire; 1 = enter HALT.
REQ-009 pc_value  in  I_ADDR_W  current program counter.
REQ-010 imem_req  out  1  instruction fetch request.
REQ-011 imem_addr  out  I_ADDR_W  fetch address.
REQ-012 imem_ready  in  1  memory accepts request this cycle.
REQ-013 imem_rsp_valid  in  1  fetch data valid.
REQ-014 imem_rsp_data  in  INST_W  fetched instruction.
REQ-015 instruction  out  INST_W  instruction register; feeds the decoder.
REQ-016 dec_dmem_we, dec_dmem_oe  in  1 each  decoder memory store/load strobes.
REQ-017 dmem_req  out  1  data memory access in progress.
REQ-018 dmem_ack  in  1  data memory access complete.
REQ-019 exec_commit  out  1  qualifies all decoder write enables (acc, register, status, memory) for this cycle.
REQ-020 pc_advance  out  1  one-cycle pulse; program counter updates (increment or jump/branch).
REQ-021 halted  out  1  1 while in HALT.
REQ-022 retired_count  out  CNT_W  retired-instruction count.

Function
REQ-023 States: IDLE, FETCH_REQ, FETCH_WAIT, EXECUTE, MEM_WAIT, HALT; encoding free.
REQ-024 IDLE: outputs inactive; run=1 -> FETCH_REQ next cycle.
REQ-025 FETCH_REQ: imem_req=1 and imem_addr=pc_value; imem_req held until imem_ready=1; on imem_ready -> FETCH_WAIT.
REQ-026 FETCH_WAIT: on imem_rsp_valid, instruction <= imem_rsp_data -> EXECUTE; imem_rsp_valid in any other state is ignored.
REQ-027 instruction SHALL change only on a FETCH_WAIT capture and SHALL be stable from EXECUTE through retire.
REQ-028 EXECUTE, dec_dmem_we=0 and dec_dmem_oe=0: exec_commit=1 and pc_advance=1 for one cycle; instruction retires.
REQ-029 EXECUTE, dec_dmem_we=1 or dec_dmem_oe=1: -> MEM_WAIT; exec_commit=0 and pc_advance=0 in EXECUTE.
REQ-030 MEM_WAIT: dmem_req=1 until dmem_ack; in the dmem_ack cycle, exec_commit=1 and pc_advance=1; instruction retires.
REQ-031 Retire-cycle next state, by priority: halt_req=1 -> HALT; else run=0 -> IDLE; else FETCH_REQ.
REQ-032 HALT is exited only by reset; halted=1 and all other strobes are 0.
REQ-033 run deasserting mid-instruction SHALL NOT abort it; the instruction completes and the block stops at retire.
REQ-034 retired_count increments by 1 on each retire; wraps from 2^CNT_W-1 to 0.
REQ-035 Minimum latency, fetch to retire with zero-wait memory: FETCH_REQ, FETCH_WAIT, EXECUTE = 3 cycles per non-memory instruction.
REQ-036 exec_commit and pc_advance are never 1 outside a retire cycle; each is asserted exactly once per instruction.

Reset
REQ-037 While rst_n=0: state=IDLE; instruction=0; retired_count=0; imem_req, dmem_req, exec_commit, pc_advance and halted = 0; imem_addr follows pc_value.
REQ-038 Reset asserted in any state, including mid-fetch or MEM_WAIT, SHALL abandon the operation immediately with no commit.
REQ-039 After rst_n rises, the first fetch SHALL start no earlier than the first clk edge with run=1.

Verification
REQ-040 Non-memory instruction, run=1, zero-wait memory, imem_rsp_data=16'h1234 -> imem_req in cycle 1, capture in cycle 2, exec_commit=pc_advance=1 in cycle 3, retired_count=1.
REQ-041 imem_ready held 0 for 4 cycles -> imem_req and imem_addr held stable for 5 cycles, no commit in that time.
REQ-042 Store with dec_dmem_we=1, dmem_ack after 3 cycles -> dmem_req=1 for 3 cycles, single exec_commit in the ack cycle.
REQ-043 run dropped during MEM_WAIT -> the access completes, one retire, then IDLE with no further imem_req.
REQ-044 halt_req=1 at retire -> halted=1, no fetch for 20 cycles; rst_n pulse -> IDLE, retired_count=0.
REQ-045 CNT_W=4, 17 retires -> retired_count=1 (wrap).
